// File: rtl/pong_game_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pong_game_engine_if                                           |
// | Purpose  : Bundles the frame sync, player controls and the game-state    |
// |            outputs of the Pong engine.                                   |
// | Ports    : master - timing/input side (drives iVS and controls, reads    |
// |                     positions, scores and status)                        |
// |            slave  - the game engine                                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface pong_game_engine_if #(
   parameter int CW      = 10,
   parameter int SCORE_W = 4
);
   logic               iVS;
   logic               w_in;
   logic               s_in;
   logic               o_in;
   logic               l_in;
   logic               pause_in;
   logic               restart_in;
   logic [CW-1:0]      paddle_l_y;
   logic [CW-1:0]      paddle_r_y;
   logic [CW-1:0]      ball_x;
   logic [CW-1:0]      ball_y;
   logic [SCORE_W-1:0] score_l;
   logic [SCORE_W-1:0] score_r;
   logic [1:0]         state;
   logic               winner;
   logic [3:0]         ball_speed;

   modport master (
      output iVS, w_in, s_in, o_in, l_in, pause_in, restart_in,
      input  paddle_l_y, paddle_r_y, ball_x, ball_y,
             score_l, score_r, state, winner, ball_speed
   );

   modport slave (
      input  iVS, w_in, s_in, o_in, l_in, pause_in, restart_in,
      output paddle_l_y, paddle_r_y, ball_x, ball_y,
             score_l, score_r, state, winner, ball_speed
   );
endinterface
`default_nettype wire

// File: rtl/pong_game_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pong_game_engine                                              |
// | Purpose  : Pong game state. Advances paddles and ball once per video     |
// |            frame on the rising edge of vertical sync, with serve, play   |
// |            and game-over states, pause, restart and ball speed-up.       |
// | Ports    : iVGA_CLK - pixel clock, all state on its rising edge          |
// |            iRST_n   - asynchronous active-low reset                      |
// |            bus      - slave side: iVS, paddle controls, pause, restart   |
// |                       in; paddle/ball positions, scores, state, winner,  |
// |                       ball speed out (all registered)                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pong_game_engine #(
   parameter int SCREEN_W        = 640,
   parameter int SCREEN_H        = 480,
   parameter int CW              = 10,
   parameter int BALL_SIZE       = 10,
   parameter int PADDLE_W        = 10,
   parameter int PADDLE_H        = 40,
   parameter int PAD_L_X         = 20,
   parameter int PAD_R_X         = 610,
   parameter int PADDLE_SPEED    = 4,
   parameter int BALL_SPEED_INIT = 3,
   parameter int BALL_SPEED_MAX  = 8,
   parameter int SERVE_FRAMES    = 60,
   parameter int SCORE_W         = 4,
   parameter int WIN_SCORE       = 5
) (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   pong_game_engine_if.slave bus
);

   localparam int SCNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

   // Geometry is held one bit wider than coordinates so sums never wrap.
   localparam logic [CW:0] c_pspd    = (CW+1)'(PADDLE_SPEED);
   localparam logic [CW:0] c_pad_max = (CW+1)'(SCREEN_H - PADDLE_H);
   localparam logic [CW:0] c_pad_ctr = (CW+1)'((SCREEN_H - PADDLE_H) / 2);
   localparam logic [CW:0] c_bs      = (CW+1)'(BALL_SIZE);
   localparam logic [CW:0] c_pw      = (CW+1)'(PADDLE_W);
   localparam logic [CW:0] c_ph      = (CW+1)'(PADDLE_H);
   localparam logic [CW:0] c_pl_x    = (CW+1)'(PAD_L_X);
   localparam logic [CW:0] c_pr_x    = (CW+1)'(PAD_R_X);
   localparam logic [CW:0] c_l_edge  = (CW+1)'(PAD_L_X + PADDLE_W);
   localparam logic [CW:0] c_r_edge  = (CW+1)'(PAD_R_X - BALL_SIZE);
   localparam logic [CW:0] c_scr_w   = (CW+1)'(SCREEN_W);
   localparam logic [CW:0] c_scr_h   = (CW+1)'(SCREEN_H);
   localparam logic [CW:0] c_bx_ctr  = (CW+1)'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [CW:0] c_by_ctr  = (CW+1)'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [CW:0] c_by_max  = (CW+1)'(SCREEN_H - BALL_SIZE);
   localparam logic [3:0]  c_spd_ini = 4'(BALL_SPEED_INIT);
   localparam logic [3:0]  c_spd_max = 4'(BALL_SPEED_MAX);
   localparam logic [SCORE_W-1:0] c_win        = SCORE_W'(WIN_SCORE);
   localparam logic [SCNT_W-1:0]  c_serve_last = SCNT_W'(SERVE_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_SERVE = 2'b00,
      ST_PLAY  = 2'b01,
      ST_OVER  = 2'b10
   } state_t;

   state_t             state_q;
   logic [CW-1:0]      paddle_l_q, paddle_r_q, paddle_l_d, paddle_r_d;
   logic [CW-1:0]      ball_x_q, ball_y_q;
   logic [SCORE_W-1:0] score_l_q, score_r_q;
   logic [3:0]         speed_q;
   logic [SCNT_W-1:0]  serve_cnt_q;
   logic               winner_q;
   logic               dir_x_q;      // 1: moving right
   logic               dir_y_q;      // 1: moving down
   logic               last_vs_q;

   logic               w_tick;
   logic [CW:0]        w_bx, w_by, w_pl, w_pr, w_spd;
   logic               w_hit_l, w_hit_r, w_miss_l, w_miss_r, w_point;
   logic               w_bounce_top, w_bounce_bot;
   logic [3:0]         w_spd_up;
   logic [SCORE_W-1:0] w_score_l_nx, w_score_r_nx;

   // Up/down move with clamping; both buttons together cancel.
   function automatic logic [CW-1:0] paddle_next(input logic [CW-1:0] y,
                                                 input logic up,
                                                 input logic dn);
      logic [CW:0] ye;
      ye = {1'b0, y};
      if (up && !dn)
         return (ye >= c_pspd) ? CW'(ye - c_pspd) : '0;
      else if (dn && !up)
         return ((ye + c_pspd) <= c_pad_max) ? CW'(ye + c_pspd) : CW'(c_pad_max);
      else
         return y;
   endfunction

   assign paddle_l_d = paddle_next(paddle_l_q, bus.w_in, bus.s_in);
   assign paddle_r_d = paddle_next(paddle_r_q, bus.o_in, bus.l_in);

   assign w_tick = bus.iVS & ~last_vs_q;
   assign w_bx   = {1'b0, ball_x_q};
   assign w_by   = {1'b0, ball_y_q};
   assign w_pl   = {1'b0, paddle_l_q};
   assign w_pr   = {1'b0, paddle_r_q};
   assign w_spd  = (CW+1)'(speed_q);

   assign w_hit_l = !dir_x_q && (w_bx <= c_l_edge) && (w_bx + c_bs > c_pl_x)
                    && (w_by + c_bs > w_pl) && (w_by < w_pl + c_ph);
   assign w_hit_r = dir_x_q && (w_bx + c_bs >= c_pr_x) && (w_bx < c_pr_x + c_pw)
                    && (w_by + c_bs > w_pr) && (w_by < w_pr + c_ph);
   assign w_miss_l = !dir_x_q && (w_bx < w_spd);
   assign w_miss_r =  dir_x_q && (w_bx + c_bs + w_spd > c_scr_w);
   // A paddle hit takes precedence over a miss in the same frame.
   assign w_point  = !w_hit_l && !w_hit_r && (w_miss_l || w_miss_r);

   assign w_bounce_top = !dir_y_q && (w_by < w_spd);
   assign w_bounce_bot =  dir_y_q && (w_by + c_bs + w_spd > c_scr_h);

   assign w_spd_up     = (speed_q >= c_spd_max) ? c_spd_max : speed_q + 4'd1;
   assign w_score_l_nx = score_l_q + SCORE_W'(1);
   assign w_score_r_nx = score_r_q + SCORE_W'(1);

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q     <= ST_SERVE;
         paddle_l_q  <= CW'(c_pad_ctr);
         paddle_r_q  <= CW'(c_pad_ctr);
         ball_x_q    <= CW'(c_bx_ctr);
         ball_y_q    <= CW'(c_by_ctr);
         score_l_q   <= '0;
         score_r_q   <= '0;
         speed_q     <= c_spd_ini;
         serve_cnt_q <= '0;
         winner_q    <= 1'b0;
         dir_x_q     <= 1'b1;
         dir_y_q     <= 1'b1;
         last_vs_q   <= 1'b1;   // sync already high at release is not a frame start
      end else begin
         last_vs_q <= bus.iVS;
         if (w_tick && !bus.pause_in) begin
            unique case (state_q)
               ST_SERVE: begin
                  paddle_l_q <= paddle_l_d;
                  paddle_r_q <= paddle_r_d;
                  if (serve_cnt_q == c_serve_last) begin
                     serve_cnt_q <= '0;
                     state_q     <= ST_PLAY;
                  end else begin
                     serve_cnt_q <= serve_cnt_q + SCNT_W'(1);
                  end
               end
               ST_PLAY: begin
                  paddle_l_q <= paddle_l_d;
                  paddle_r_q <= paddle_r_d;
                  if (w_point) begin
                     ball_x_q <= CW'(c_bx_ctr);
                     ball_y_q <= CW'(c_by_ctr);
                     speed_q  <= c_spd_ini;
                     // Next serve heads toward whoever conceded.
                     dir_x_q  <= w_miss_r;
                     if (w_miss_l) begin
                        score_r_q <= w_score_r_nx;
                        winner_q  <= 1'b1;
                        state_q   <= (w_score_r_nx == c_win) ? ST_OVER : ST_SERVE;
                     end else begin
                        score_l_q <= w_score_l_nx;
                        winner_q  <= 1'b0;
                        state_q   <= (w_score_l_nx == c_win) ? ST_OVER : ST_SERVE;
                     end
                  end else begin
                     if (w_hit_l) begin
                        ball_x_q <= CW'(c_l_edge);
                        dir_x_q  <= 1'b1;
                        speed_q  <= w_spd_up;
                     end else if (w_hit_r) begin
                        ball_x_q <= CW'(c_r_edge);
                        dir_x_q  <= 1'b0;
                        speed_q  <= w_spd_up;
                     end else begin
                        ball_x_q <= dir_x_q ? CW'(w_bx + w_spd) : CW'(w_bx - w_spd);
                     end
                     if (w_bounce_top) begin
                        ball_y_q <= '0;
                        dir_y_q  <= 1'b1;
                     end else if (w_bounce_bot) begin
                        ball_y_q <= CW'(c_by_max);
                        dir_y_q  <= 1'b0;
                     end else begin
                        ball_y_q <= dir_y_q ? CW'(w_by + w_spd) : CW'(w_by - w_spd);
                     end
                  end
               end
               ST_OVER: begin
                  if (bus.restart_in) begin
                     score_l_q   <= '0;
                     score_r_q   <= '0;
                     speed_q     <= c_spd_ini;
                     ball_x_q    <= CW'(c_bx_ctr);
                     ball_y_q    <= CW'(c_by_ctr);
                     dir_x_q     <= 1'b1;
                     serve_cnt_q <= '0;
                     state_q     <= ST_SERVE;
                  end
               end
               default: state_q <= ST_SERVE;
            endcase
         end
      end
   end

   assign bus.paddle_l_y = paddle_l_q;
   assign bus.paddle_r_y = paddle_r_q;
   assign bus.ball_x     = ball_x_q;
   assign bus.ball_y     = ball_y_q;
   assign bus.score_l    = score_l_q;
   assign bus.score_r    = score_r_q;
   assign bus.state      = state_q;
   assign bus.winner     = winner_q;
   assign bus.ball_speed = speed_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pong_game_engine                                           |
// | Purpose  : Directed self-checking bench for pong_game_engine with the    |
// |            default 640x480 geometry. Frames are two clocks long (iVS    |
// |            low one cycle, then high), so every frame is exactly one tick.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pong_game_engine;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   pong_game_engine_if #(.CW(10), .SCORE_W(4)) bus ();

   pong_game_engine dut (
      .iVGA_CLK (clk),
      .iRST_n   (rst_n),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.w_in = 1'b0; bus.s_in = 1'b0; bus.o_in = 1'b0; bus.l_in = 1'b0;
      bus.pause_in = 1'b0; bus.restart_in = 1'b0;
   endtask

   // Reset with iVS high; leaves iVS high and time at posedge+1.
   task automatic do_reset();
      rst_n  = 1'b0;
      bus.iVS = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // One video frame: one clock with iVS low, then iVS rises; outputs
   // are sampled 1 time unit after the edge that detects the rise.
   task automatic frame();
      bus.iVS = 1'b0;
      @(posedge clk); #1;
      bus.iVS = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic test_reset();
      do_reset();
      bus.w_in = 1'b1;            // would move the paddle on a spurious tick
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (bus.paddle_l_y !== 10'd220) begin n_bad++; $display("FAIL rst_pad_l: got %0d want 220", bus.paddle_l_y); end
      n_cmp++; if (bus.paddle_r_y !== 10'd220) begin n_bad++; $display("FAIL rst_pad_r: got %0d want 220", bus.paddle_r_y); end
      n_cmp++; if (bus.ball_x !== 10'd315 || bus.ball_y !== 10'd235) begin n_bad++; $display("FAIL rst_ball: got (%0d,%0d) want (315,235)", bus.ball_x, bus.ball_y); end
      n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL rst_state: got %b want 00", bus.state); end
      n_cmp++; if (bus.score_l !== 4'd0 || bus.score_r !== 4'd0) begin n_bad++; $display("FAIL rst_score: got %0d/%0d want 0/0", bus.score_l, bus.score_r); end
      n_cmp++; if (bus.ball_speed !== 4'd3 || bus.winner !== 1'b0) begin n_bad++; $display("FAIL rst_speed_winner: got %0d/%0d want 3/0", bus.ball_speed, bus.winner); end
      bus.w_in = 1'b0;
   endtask

   task automatic test_paddles();
      do_reset();
      bus.w_in = 1'b1; bus.s_in = 1'b1; bus.o_in = 1'b1; bus.l_in = 1'b1;
      frame();
      n_cmp++; if (bus.paddle_l_y !== 10'd220 || bus.paddle_r_y !== 10'd220) begin n_bad++; $display("FAIL pad_both: got %0d/%0d want 220/220", bus.paddle_l_y, bus.paddle_r_y); end
      bus.s_in = 1'b0; bus.o_in = 1'b0;   // left up, right down
      frame();
      n_cmp++; if (bus.paddle_l_y !== 10'd216 || bus.paddle_r_y !== 10'd224) begin n_bad++; $display("FAIL pad_step1: got %0d/%0d want 216/224", bus.paddle_l_y, bus.paddle_r_y); end
      frame();
      n_cmp++; if (bus.paddle_l_y !== 10'd212 || bus.paddle_r_y !== 10'd228) begin n_bad++; $display("FAIL pad_step2: got %0d/%0d want 212/228", bus.paddle_l_y, bus.paddle_r_y); end
      frames(53);
      n_cmp++; if (bus.paddle_l_y !== 10'd0 || bus.paddle_r_y !== 10'd440) begin n_bad++; $display("FAIL pad_limit: got %0d/%0d want 0/440", bus.paddle_l_y, bus.paddle_r_y); end
      frames(2);
      n_cmp++; if (bus.paddle_l_y !== 10'd0 || bus.paddle_r_y !== 10'd440) begin n_bad++; $display("FAIL pad_clamp: got %0d/%0d want 0/440", bus.paddle_l_y, bus.paddle_r_y); end
      n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL pad_state: got %b want 00", bus.state); end
      idle_inputs();
   endtask

   task automatic test_serve();
      do_reset();
      frames(59);
      n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL serve_59: got %b want 00", bus.state); end
      bus.iVS = 1'b0;
      @(posedge clk); #1;
      bus.iVS = 1'b1;
      n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL serve_pre_edge: got %b want 00", bus.state); end
      @(posedge clk); #1;
      n_cmp++; if (bus.state !== 2'b01) begin n_bad++; $display("FAIL serve_60: got %b want 01", bus.state); end
      n_cmp++; if (bus.ball_x !== 10'd315 || bus.ball_y !== 10'd235) begin n_bad++; $display("FAIL serve_ball_held: got (%0d,%0d) want (315,235)", bus.ball_x, bus.ball_y); end
      frame();
      n_cmp++; if (bus.ball_x !== 10'd318 || bus.ball_y !== 10'd238) begin n_bad++; $display("FAIL play_first_move: got (%0d,%0d) want (318,238)", bus.ball_x, bus.ball_y); end

      // Pause mid-serve delays the transition by the paused frames.
      do_reset();
      frames(30);
      bus.pause_in = 1'b1; bus.w_in = 1'b1;
      frames(10);
      n_cmp++; if (bus.paddle_l_y !== 10'd220) begin n_bad++; $display("FAIL pause_paddle: got %0d want 220", bus.paddle_l_y); end
      bus.pause_in = 1'b0; bus.w_in = 1'b0;
      frames(29);
      n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL pause_serve_59: got %b want 00", bus.state); end
      frame();
      n_cmp++; if (bus.state !== 2'b01) begin n_bad++; $display("FAIL pause_serve_60: got %b want 01", bus.state); end
   endtask

   task automatic test_rally();
      do_reset();
      bus.l_in = 1'b1;
      frames(45);
      bus.l_in = 1'b0;
      n_cmp++; if (bus.paddle_r_y !== 10'd400) begin n_bad++; $display("FAIL rally_pad_r: got %0d want 400", bus.paddle_r_y); end
      frames(15 + 95);
      n_cmp++; if (bus.ball_x !== 10'd600 || bus.ball_y !== 10'd422) begin n_bad++; $display("FAIL rally_pre_hit: got (%0d,%0d) want (600,422)", bus.ball_x, bus.ball_y); end
      frame();   // right paddle hit
      n_cmp++; if (bus.ball_x !== 10'd600 || bus.ball_y !== 10'd419 || bus.ball_speed !== 4'd4) begin n_bad++; $display("FAIL right_hit: got x=%0d y=%0d spd=%0d want 600 419 4", bus.ball_x, bus.ball_y, bus.ball_speed); end
      frames(150);
      n_cmp++; if (bus.ball_x !== 10'd0 || bus.ball_y !== 10'd180 || bus.score_r !== 4'd0) begin n_bad++; $display("FAIL pre_left_miss: got x=%0d y=%0d sr=%0d want 0 180 0", bus.ball_x, bus.ball_y, bus.score_r); end
      frame();   // left miss
      n_cmp++; if (bus.score_r !== 4'd1 || bus.score_l !== 4'd0) begin n_bad++; $display("FAIL left_miss_score: got %0d/%0d want 0/1", bus.score_l, bus.score_r); end
      n_cmp++; if (bus.ball_x !== 10'd315 || bus.ball_y !== 10'd235 || bus.ball_speed !== 4'd3 || bus.state !== 2'b00) begin n_bad++; $display("FAIL left_miss_reset: got x=%0d y=%0d spd=%0d st=%b want 315 235 3 00", bus.ball_x, bus.ball_y, bus.ball_speed, bus.state); end

      bus.s_in = 1'b1;
      frames(50);
      bus.s_in = 1'b0;
      n_cmp++; if (bus.paddle_l_y !== 10'd420) begin n_bad++; $display("FAIL rally_pad_l: got %0d want 420", bus.paddle_l_y); end
      frames(11);
      n_cmp++; if (bus.ball_x !== 10'd312 || bus.ball_y !== 10'd238) begin n_bad++; $display("FAIL serve_toward_left: got (%0d,%0d) want (312,238)", bus.ball_x, bus.ball_y); end
      frames(94);
      n_cmp++; if (bus.ball_x !== 10'd30 || bus.ball_y !== 10'd422) begin n_bad++; $display("FAIL pre_left_hit: got (%0d,%0d) want (30,422)", bus.ball_x, bus.ball_y); end
      frame();   // left paddle hit at x=30
      n_cmp++; if (bus.ball_x !== 10'd30 || bus.ball_y !== 10'd419 || bus.ball_speed !== 4'd4) begin n_bad++; $display("FAIL left_hit: got x=%0d y=%0d spd=%0d want 30 419 4", bus.ball_x, bus.ball_y, bus.ball_speed); end

      bus.o_in = 1'b1;
      frames(62);
      bus.o_in = 1'b0;
      n_cmp++; if (bus.paddle_r_y !== 10'd152) begin n_bad++; $display("FAIL rally_pad_r2: got %0d want 152", bus.paddle_r_y); end
      frames(81);
      n_cmp++; if (bus.ball_x !== 10'd602 || bus.ball_y !== 10'd152) begin n_bad++; $display("FAIL pre_right_hit2: got (%0d,%0d) want (602,152)", bus.ball_x, bus.ball_y); end
      frame();   // second hit, ball snapped back to x=600
      n_cmp++; if (bus.ball_x !== 10'd600 || bus.ball_y !== 10'd156 || bus.ball_speed !== 4'd5) begin n_bad++; $display("FAIL right_hit2: got x=%0d y=%0d spd=%0d want 600 156 5", bus.ball_x, bus.ball_y, bus.ball_speed); end
   endtask

   task automatic test_game_over();
      do_reset();
      bus.w_in = 1'b1;
      frames(5);
      bus.w_in = 1'b0;
      frames(55 + 106);
      n_cmp++; if (bus.score_l !== 4'd1 || bus.score_r !== 4'd0 || bus.state !== 2'b00) begin n_bad++; $display("FAIL right_miss1: got sl=%0d sr=%0d st=%b want 1 0 00", bus.score_l, bus.score_r, bus.state); end
      n_cmp++; if (bus.ball_x !== 10'd315 || bus.ball_y !== 10'd235 || bus.ball_speed !== 4'd3) begin n_bad++; $display("FAIL right_miss1_ball: got x=%0d y=%0d spd=%0d want 315 235 3", bus.ball_x, bus.ball_y, bus.ball_speed); end
      for (int r = 2; r <= 4; r++) begin
         frames(166);
         n_cmp++; if (bus.score_l !== 4'(r) || bus.state !== 2'b00) begin n_bad++; $display("FAIL right_miss_round%0d: got sl=%0d st=%b want %0d 00", r, bus.score_l, bus.state, r); end
      end
      frames(166);
      n_cmp++; if (bus.score_l !== 4'd5 || bus.state !== 2'b10 || bus.winner !== 1'b0) begin n_bad++; $display("FAIL game_over: got sl=%0d st=%b win=%0d want 5 10 0", bus.score_l, bus.state, bus.winner); end
      bus.w_in = 1'b1;
      frames(3);
      bus.w_in = 1'b0;
      n_cmp++; if (bus.paddle_l_y !== 10'd200 || bus.score_l !== 4'd5 || bus.state !== 2'b10 || bus.ball_x !== 10'd315) begin n_bad++; $display("FAIL over_frozen: got pl=%0d sl=%0d st=%b x=%0d want 200 5 10 315", bus.paddle_l_y, bus.score_l, bus.state, bus.ball_x); end
      bus.restart_in = 1'b1;
      frame();
      bus.restart_in = 1'b0;
      n_cmp++; if (bus.score_l !== 4'd0 || bus.score_r !== 4'd0 || bus.state !== 2'b00 || bus.ball_speed !== 4'd3) begin n_bad++; $display("FAIL restart: got sl=%0d sr=%0d st=%b spd=%0d want 0 0 00 3", bus.score_l, bus.score_r, bus.state, bus.ball_speed); end
      n_cmp++; if (bus.paddle_l_y !== 10'd200 || bus.ball_x !== 10'd315 || bus.ball_y !== 10'd235) begin n_bad++; $display("FAIL restart_pos: got pl=%0d x=%0d y=%0d want 200 315 235", bus.paddle_l_y, bus.ball_x, bus.ball_y); end
   endtask

   initial begin
      rst_n   = 1'b0;
      bus.iVS = 1'b1;
      idle_inputs();
      test_reset();
      test_paddles();
      test_serve();
      test_rally();
      test_game_over();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
